// File: rtl/stim_seq_gen.sv
// rtl/stim_seq_gen.sv - table-driven (pattern, duration) stimulus sequencer
// Optional MISR signature over resp enabled by STIM_SEQ_SIG_EN.
module stim_seq_gen #(
    parameter int               WIDTH    = 1,
    parameter int               DEPTH    = 16,
    parameter int               CNT_W    = 8,
    parameter logic [WIDTH-1:0] IDLE_VAL = '0,
    localparam int              AW       = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_pat,
    input  logic [CNT_W-1:0] wr_dur,
    input  logic [AW:0]      seq_len,
    input  logic             loop,
    input  logic             start,
    input  logic             stop,
    output logic [WIDTH-1:0] stim,
    output logic             busy,
    output logic             done,
    output logic [AW-1:0]    step_idx
`ifdef STIM_SEQ_SIG_EN
    ,
    input  logic [WIDTH-1:0] resp,
    output logic [15:0]      sig
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] pat_mem [DEPTH];
    logic [CNT_W-1:0] dur_mem [DEPTH];
    logic [CNT_W-1:0] cnt;
    logic [AW:0]      len_q;
    logic             loop_q;

    logic             wr_ok;
    logic             start_ok;
    logic             last;
    logic             adv;
    logic [AW-1:0]    nxt_idx;
    logic [WIDTH-1:0] pat0;
    logic [CNT_W-1:0] dur0;

    function automatic logic [CNT_W-1:0] nz(input logic [CNT_W-1:0] d);
        return (d == '0) ? CNT_W'(1) : d;
    endfunction

    assign wr_ok    = wr_en && (state == S_IDLE) && !rst;
    assign start_ok = (state == S_IDLE) && start && !stop &&
                      (seq_len != '0) && (seq_len <= (AW+1)'(DEPTH));
    assign last     = ({1'b0, step_idx} == (len_q - (AW+1)'(1)));
    assign adv      = (cnt == CNT_W'(1));
    assign nxt_idx  = last ? '0 : step_idx + AW'(1);

    // A write landing on entry 0 in the start cycle must be visible immediately.
    assign pat0 = (wr_ok && wr_addr == '0) ? wr_pat : pat_mem[0];
    assign dur0 = (wr_ok && wr_addr == '0) ? wr_dur : dur_mem[0];

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            pat_mem[wr_addr] <= wr_pat;
            dur_mem[wr_addr] <= wr_dur;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            stim     <= IDLE_VAL;
            busy     <= 1'b0;
            done     <= 1'b0;
            step_idx <= '0;
            cnt      <= CNT_W'(1);
            len_q    <= '0;
            loop_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start_ok) begin
                        state    <= S_RUN;
                        stim     <= pat0;
                        cnt      <= nz(dur0);
                        step_idx <= '0;
                        busy     <= 1'b1;
                        len_q    <= seq_len;
                        loop_q   <= loop;
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        state    <= S_IDLE;
                        stim     <= IDLE_VAL;
                        busy     <= 1'b0;
                        step_idx <= '0;
                    end else if (adv) begin
                        if (last && !loop_q) begin
                            state    <= S_DONE;
                            stim     <= IDLE_VAL;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            step_idx <= '0;
                        end else begin
                            step_idx <= nxt_idx;
                            stim     <= pat_mem[nxt_idx];
                            cnt      <= nz(dur_mem[nxt_idx]);
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef STIM_SEQ_SIG_EN
    localparam int RW = (WIDTH < 16) ? WIDTH : 16;
    logic [15:0] resp16;

    assign resp16 = 16'(resp[RW-1:0]);

    // x^16+x^12+x^5+1, shift-left form; holds outside RUN.
    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            sig <= 16'hFFFF;
        end else if (state == S_RUN) begin
            sig <= {sig[14:0], 1'b0} ^ (sig[15] ? 16'h1021 : 16'h0000) ^ resp16;
        end
    end
`endif

endmodule

// File: tb/tb_stim_seq_gen.sv
// tb/tb_stim_seq_gen.sv - scoreboard bench for stim_seq_gen
// Builds with or without STIM_SEQ_SIG_EN.
module tb_stim_seq_gen;

    localparam int W  = 2;
    localparam int D  = 4;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [1:0]    wr_addr;
    logic [W-1:0]  wr_pat;
    logic [CW-1:0] wr_dur;
    logic [2:0]    seq_len;
    logic          loop;
    logic          start;
    logic          stop;
    logic [W-1:0]  stim;
    logic          busy;
    logic          done;
    logic [1:0]    step_idx;
`ifdef STIM_SEQ_SIG_EN
    logic [W-1:0]  resp;
    logic [W-1:0]  resp_flip = '0;
    logic [15:0]   sig;
    logic [15:0]   sig_q[$];
    assign resp = stim ^ resp_flip;
`endif

    always #5 clk = ~clk;

    stim_seq_gen #(.WIDTH(W), .DEPTH(D), .CNT_W(CW), .IDLE_VAL(2'b00)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_pat(wr_pat),
        .wr_dur(wr_dur), .seq_len(seq_len), .loop(loop), .start(start), .stop(stop),
        .stim(stim), .busy(busy), .done(done), .step_idx(step_idx)
`ifdef STIM_SEQ_SIG_EN
        , .resp(resp), .sig(sig)
`endif
    );

    typedef struct packed {
        logic [7:0] tag;
        logic [1:0] st;
        logic       bz;
        logic       dn;
        logic [1:0] ix;
        logic       ci;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   errors = 0;
    int   checks = 0;

    function automatic void px(int t, logic [1:0] s, logic b, logic d, logic [1:0] i, logic c);
        exp_t x;
        x.tag = 8'(t); x.st = s; x.bz = b; x.dn = d; x.ix = i; x.ci = c;
        exp_q.push_back(x);
    endfunction

    function automatic void pidle(int t, int n);
        for (int k = 0; k < n; k++) px(t, 2'b00, 1'b0, 1'b0, 2'd0, 1'b1);
    endfunction

    function automatic void pdone(int t);
        px(t, 2'b00, 1'b0, 1'b1, 2'd0, 1'b0);
        pidle(t, 1);
    endfunction

    function automatic logic [15:0] misr(input logic [15:0] s, input logic [15:0] v);
        logic [15:0] n;
        n = {s[14:0], 1'b0};
        if (s[15]) n = n ^ 16'h1021;
        return n ^ v;
    endfunction

    // Monitor: one expected word per cycle while the scoreboard holds entries.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (stim !== e.st || busy !== e.bz || done !== e.dn || (e.ci && step_idx !== e.ix)) begin
                    errors++;
                    $display("FAIL trace t%0d: got stim=%b busy=%b done=%b idx=%0d, want stim=%b busy=%b done=%b idx=%0d",
                             e.tag, stim, busy, done, step_idx, e.st, e.bz, e.dn, e.ix);
                end
            end
`ifdef STIM_SEQ_SIG_EN
            if (done === 1'b1 && sig_q.size() > 0) begin
                logic [15:0] es;
                es = sig_q.pop_front();
                checks++;
                if (sig !== es) begin
                    errors++;
                    $display("FAIL sig: got %h want %h", sig, es);
                end
            end
`endif
        end
    end

    task automatic wr(input logic [1:0] a, input logic [1:0] p, input logic [7:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_pat = p; wr_dur = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        if (exp_q.size() > 0) begin
            errors++; checks++;
            $display("FAIL drain timeout: %0d entries left, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic pulse_start_idle(input int t, input logic [2:0] len, input logic stp);
        seq_len = len;
        @(negedge clk);
        start = 1'b1; stop = stp;
        pidle(t, 3);
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        drain();
    endtask

    task automatic push_four(input int t);
        px(t, 2'b01, 1, 0, 2'd0, 1); px(t, 2'b10, 1, 0, 2'd1, 1);
        px(t, 2'b11, 1, 0, 2'd2, 1); px(t, 2'b10, 1, 0, 2'd3, 1);
        pdone(t);
    endtask

    task automatic push_t1(input int t);
        for (int k = 0; k < 3; k++) px(t, 2'b01, 1, 0, 2'd0, 1);
        px(t, 2'b10, 1, 0, 2'd1, 1);
        px(t, 2'b11, 1, 0, 2'd2, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_pat = '0; wr_dur = '0;
        seq_len = '0; loop = 1'b0; start = 1'b0; stop = 1'b0;

        // reset state
        @(negedge clk);
        pidle(0, 2);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        drain();

        // one-shot playback
        wr(2'd0, 2'b01, 8'd3);
        wr(2'd1, 2'b10, 8'd1);
        wr(2'd2, 2'b11, 8'd0);
        seq_len = 3'd3; loop = 1'b0;
        @(negedge clk);
        start = 1'b1;
        push_t1(1);
        pdone(1);
        @(negedge clk);
        start = 1'b0;
        drain();

        // looping, latched loop, stop mid-step with no done
        loop = 1'b1;
        @(negedge clk);
        start = 1'b1;
        push_t1(2); push_t1(2);
        px(2, 2'b01, 1, 0, 2'd0, 1); px(2, 2'b01, 1, 0, 2'd0, 1);
        pidle(2, 3);
        @(negedge clk);
        start = 1'b0; loop = 1'b0;
        repeat (11) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        drain();

        // rejected starts
        pulse_start_idle(3, 3'd0, 1'b0);
        pulse_start_idle(3, 3'd5, 1'b0);
        pulse_start_idle(3, 3'd3, 1'b1);

        // full-depth table, dur 1 and dur 0
        wr(2'd0, 2'b01, 8'd1);
        wr(2'd1, 2'b10, 8'd1);
        wr(2'd2, 2'b11, 8'd1);
        wr(2'd3, 2'b10, 8'd0);
        seq_len = 3'd4;
        @(negedge clk);
        start = 1'b1;
        push_four(3);
        @(negedge clk);
        start = 1'b0;
        drain();

        // write during RUN is ignored
        @(negedge clk);
        start = 1'b1;
        push_four(4);
        @(negedge clk);
        start = 1'b0;
        wr_en = 1'b1; wr_addr = 2'd1; wr_pat = 2'b00; wr_dur = 8'd7;
        @(negedge clk);
        wr_en = 1'b0;
        drain();
        @(negedge clk);
        start = 1'b1;
        push_four(4);
        @(negedge clk);
        start = 1'b0;
        drain();

        // write and start in the same cycle
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 2'd0; wr_pat = 2'b11; wr_dur = 8'd2;
        seq_len = 3'd2; start = 1'b1;
        px(4, 2'b11, 1, 0, 2'd0, 1); px(4, 2'b11, 1, 0, 2'd0, 1);
        px(4, 2'b10, 1, 0, 2'd1, 1);
        pdone(4);
        @(negedge clk);
        wr_en = 1'b0; start = 1'b0;
        drain();

        // reset mid-step, table survives
        wr(2'd0, 2'b10, 8'd5);
        wr(2'd1, 2'b01, 8'd1);
        seq_len = 3'd2;
        @(negedge clk);
        start = 1'b1;
        px(5, 2'b10, 1, 0, 2'd0, 1); px(5, 2'b10, 1, 0, 2'd0, 1);
        pidle(5, 3);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drain();
        seq_len = 3'd2;
        @(negedge clk);
        start = 1'b1;
        for (int k = 0; k < 5; k++) px(5, 2'b10, 1, 0, 2'd0, 1);
        px(5, 2'b01, 1, 0, 2'd1, 1);
        pdone(5);
        @(negedge clk);
        start = 1'b0;
        drain();

`ifdef STIM_SEQ_SIG_EN
        // signature: two identical runs, then one with a flipped resp bit
        wr(2'd0, 2'b01, 8'd3);
        wr(2'd1, 2'b10, 8'd1);
        wr(2'd2, 2'b11, 8'd0);
        seq_len = 3'd3; loop = 1'b0;
        for (int r = 0; r < 3; r++) begin
            logic [1:0]  sv [5];
            logic [15:0] s;
            sv[0] = 2'b01; sv[1] = 2'b01; sv[2] = 2'b01; sv[3] = 2'b10; sv[4] = 2'b11;
            resp_flip = (r == 2) ? 2'b01 : 2'b00;
            s = 16'hFFFF;
            for (int k = 0; k < 5; k++) s = misr(s, 16'(sv[k] ^ resp_flip));
            sig_q.push_back(s);
            @(negedge clk);
            start = 1'b1;
            push_t1(6);
            pdone(6);
            @(negedge clk);
            start = 1'b0;
            drain();
        end
        if (sig_q.size() > 0) begin
            errors++; checks++;
            $display("FAIL sig pending: %0d left, want 0", sig_q.size());
        end
`endif

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
